// File: rtl/param_backup_mem.sv
// Line-oriented backing memory: masked multi-beat writes and fixed-latency burst reads.
// Storage has no reset, so lines written before a reset survive it.
module param_backup_mem #(
    parameter int DATA_BITS  = 128,
    parameter int ADDR_BITS  = 26,
    parameter int TAG_BITS   = 5,
    parameter int BEATS      = 4,
    parameter int DEPTH_LOG2 = 14,
    parameter int LATENCY    = 4,
    localparam int OFF_BITS  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_req_valid,
    output logic                     mem_req_ready,
    input  logic                     mem_req_rw,
    input  logic [ADDR_BITS-1:0]     mem_req_addr,
    input  logic [TAG_BITS-1:0]      mem_req_tag,
    input  logic                     mem_req_data_valid,
    output logic                     mem_req_data_ready,
    input  logic [DATA_BITS-1:0]     mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0]   mem_req_data_mask,
    input  logic [OFF_BITS-1:0]      mem_req_data_offset,
    output logic                     mem_resp_valid,
    output logic [TAG_BITS-1:0]      mem_resp_tag,
    output logic [DATA_BITS-1:0]     mem_resp_data
);

    localparam int MASK_BITS = DATA_BITS / 8;
    localparam int WORD_BITS = ADDR_BITS + OFF_BITS;
    localparam int DEPTH     = 1 << DEPTH_LOG2;
    localparam int LAT_BITS  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [OFF_BITS-1:0] LAST_BEAT = OFF_BITS'(BEATS - 1);
    localparam logic [LAT_BITS-1:0] LAT_LOAD  = LAT_BITS'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   addr_q, addr_d;
    logic [TAG_BITS-1:0]    tag_q, tag_d;
    logic [OFF_BITS-1:0]    beat_q, beat_d;
    logic [LAT_BITS-1:0]    lat_q, lat_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [TAG_BITS-1:0]    resp_tag_q, resp_tag_d;
    logic [DATA_BITS-1:0]   resp_data_q, resp_data_d;

    logic                   req_fire_s;
    logic                   data_fire_s;
    logic [WORD_BITS-1:0]   wr_word_s;
    logic [DEPTH_LOG2-1:0]  wr_idx_s;
    logic [WORD_BITS-1:0]   rd_word_s;
    logic [DEPTH_LOG2-1:0]  rd_idx_s;

    logic [DATA_BITS-1:0]   mem_q [0:DEPTH-1];

    assign mem_req_ready      = (state_q == ST_IDLE) && !reset;
    assign mem_req_data_ready = (state_q == ST_WRITE);
    assign req_fire_s         = mem_req_valid && mem_req_ready;
    assign data_fire_s        = mem_req_data_valid && (state_q == ST_WRITE);

    // Upper address bits beyond the storage depth are dropped, so addresses wrap.
    assign wr_word_s = {addr_q, mem_req_data_offset};
    assign wr_idx_s  = wr_word_s[DEPTH_LOG2-1:0];
    assign rd_word_s = {addr_d, beat_d};
    assign rd_idx_s  = rd_word_s[DEPTH_LOG2-1:0];

    assign mem_resp_valid = resp_valid_q;
    assign mem_resp_tag   = resp_tag_q;
    assign mem_resp_data  = resp_data_q;

    // Next-state, beat counter and latency counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        case (state_q)
            ST_IDLE: begin
                if (req_fire_s) begin
                    addr_d = mem_req_addr;
                    tag_d  = mem_req_tag;
                    beat_d = {OFF_BITS{1'b0}};
                    if (mem_req_rw) begin
                        state_d = ST_WRITE;
                        lat_d   = {LAT_BITS{1'b0}};
                    end else if (LATENCY == 1) begin
                        state_d = ST_READ;
                        lat_d   = {LAT_BITS{1'b0}};
                    end else begin
                        state_d = ST_WAIT;
                        lat_d   = LAT_LOAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (data_fire_s) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = ST_IDLE;
                        beat_d  = {OFF_BITS{1'b0}};
                    end else begin
                        beat_d = beat_q + OFF_BITS'(1);
                    end
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_WAIT: begin
                // Leaving on a count of one puts the first beat LATENCY cycles after accept.
                if (lat_q <= LAT_BITS'(1)) begin
                    state_d = ST_READ;
                    lat_d   = {LAT_BITS{1'b0}};
                end else begin
                    lat_d = lat_q - LAT_BITS'(1);
                end
            end
            ST_READ: begin
                if (beat_q == LAST_BEAT) begin
                    state_d = ST_IDLE;
                    beat_d  = {OFF_BITS{1'b0}};
                end else begin
                    beat_d = beat_q + OFF_BITS'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                beat_d  = {OFF_BITS{1'b0}};
                lat_d   = {LAT_BITS{1'b0}};
            end
        endcase
    end

    // Response registers are loaded from the next state so each beat leaves a flop.
    always_comb begin
        resp_valid_d = 1'b0;
        resp_tag_d   = {TAG_BITS{1'b0}};
        resp_data_d  = {DATA_BITS{1'b0}};
        if (state_d == ST_READ) begin
            resp_valid_d = 1'b1;
            resp_tag_d   = tag_d;
            resp_data_d  = mem_q[rd_idx_s];
        end else begin
            resp_valid_d = 1'b0;
        end
    end

    // Control and response state with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            addr_q       <= {ADDR_BITS{1'b0}};
            tag_q        <= {TAG_BITS{1'b0}};
            beat_q       <= {OFF_BITS{1'b0}};
            lat_q        <= {LAT_BITS{1'b0}};
            resp_valid_q <= 1'b0;
            resp_tag_q   <= {TAG_BITS{1'b0}};
            resp_data_q  <= {DATA_BITS{1'b0}};
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            tag_q        <= tag_d;
            beat_q       <= beat_d;
            lat_q        <= lat_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
        end
    end

    // Byte-masked storage write.
    always_ff @(posedge clk) begin
        if (data_fire_s) begin
            for (int b = 0; b < MASK_BITS; b++) begin
                if (mem_req_data_mask[b]) begin
                    mem_q[wr_idx_s][b*8 +: 8] <= mem_req_data_bits[b*8 +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_param_backup_mem.sv
// Directed scoreboard bench for param_backup_mem: default instance plus a 1-beat, 1-cycle variant.
module tb_param_backup_mem;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         a_valid, a_ready, a_rw, a_dv, a_dready, a_rvalid;
    logic [25:0]  a_addr;
    logic [4:0]   a_tag, a_rtag;
    logic [127:0] a_bits, a_rdata;
    logic [15:0]  a_mask;
    logic [1:0]   a_off;

    logic         b_valid, b_ready, b_rw, b_dv, b_dready, b_rvalid;
    logic [25:0]  b_addr;
    logic [4:0]   b_tag, b_rtag;
    logic [63:0]  b_bits, b_rdata;
    logic [7:0]   b_mask;
    logic [0:0]   b_off;

    param_backup_mem u0 (
        .clk(clk), .reset(reset),
        .mem_req_valid(a_valid), .mem_req_ready(a_ready), .mem_req_rw(a_rw),
        .mem_req_addr(a_addr), .mem_req_tag(a_tag),
        .mem_req_data_valid(a_dv), .mem_req_data_ready(a_dready),
        .mem_req_data_bits(a_bits), .mem_req_data_mask(a_mask), .mem_req_data_offset(a_off),
        .mem_resp_valid(a_rvalid), .mem_resp_tag(a_rtag), .mem_resp_data(a_rdata)
    );

    param_backup_mem #(.DATA_BITS(64), .BEATS(1), .LATENCY(1), .DEPTH_LOG2(8)) u1 (
        .clk(clk), .reset(reset),
        .mem_req_valid(b_valid), .mem_req_ready(b_ready), .mem_req_rw(b_rw),
        .mem_req_addr(b_addr), .mem_req_tag(b_tag),
        .mem_req_data_valid(b_dv), .mem_req_data_ready(b_dready),
        .mem_req_data_bits(b_bits), .mem_req_data_mask(b_mask), .mem_req_data_offset(b_off),
        .mem_resp_valid(b_rvalid), .mem_resp_tag(b_rtag), .mem_resp_data(b_rdata)
    );

    typedef struct {
        logic [127:0] data;
        logic [4:0]   tag;
        int           cyc;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    bit [127:0] model [int];
    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [127:0] obs, input logic [127:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    function automatic int widx(input logic [25:0] addr, input int off);
        return ((int'(addr) << 2) | off) & 32'h3FFF;
    endfunction

    // Scoreboard for the default instance.
    always @(negedge clk) begin
        exp_t e;
        if (a_rvalid === 1'b1) begin
            if (q0.size() == 0) begin
                check("u0_unexpected_beat", 128'(a_rvalid), 128'd0);
            end else begin
                e = q0.pop_front();
                check("u0_resp_data", a_rdata, e.data);
                check("u0_resp_tag", 128'(a_rtag), 128'(e.tag));
                check("u0_resp_cycle", 128'(cyc), 128'(e.cyc));
            end
        end else begin
            check("u0_idle_data_zero", a_rdata, 128'd0);
        end
    end

    // Scoreboard for the single-beat instance.
    always @(negedge clk) begin
        exp_t e;
        if (b_rvalid === 1'b1) begin
            if (q1.size() == 0) begin
                check("u1_unexpected_beat", 128'(b_rvalid), 128'd0);
            end else begin
                e = q1.pop_front();
                check("u1_resp_data", 128'(b_rdata), e.data);
                check("u1_resp_tag", 128'(b_rtag), 128'(e.tag));
                check("u1_resp_cycle", 128'(cyc), 128'(e.cyc));
            end
        end
    end

    task automatic model_write(input logic [25:0] addr, input int off,
                               input logic [127:0] d, input logic [15:0] m);
        int i;
        i = widx(addr, off);
        if (!model.exists(i)) model[i] = 128'd0;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) model[i][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic wait_ready0();
        int n = 0;
        while (a_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("u0_req_ready", 128'(a_ready), 128'd1);
    endtask

    task automatic wr0(input logic [25:0] addr, input logic [4:0] tag,
                       input logic [3:0][127:0] d, input logic [3:0][15:0] m,
                       input logic [3:0][1:0] off);
        @(negedge clk);
        a_valid = 1'b1; a_rw = 1'b1; a_addr = addr; a_tag = tag;
        wait_ready0();
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_dv = 1'b1; a_bits = d[k]; a_mask = m[k]; a_off = off[k];
            check("u0_data_ready", 128'(a_dready), 128'd1);
            model_write(addr, int'(off[k]), d[k], m[k]);
            @(negedge clk);
        end
        a_dv = 1'b0;
    endtask

    task automatic push_read0(input logic [25:0] addr, input logic [4:0] tag);
        exp_t e;
        for (int k = 0; k < 4; k++) begin
            e.data = model[widx(addr, k)];
            e.tag  = tag;
            e.cyc  = cyc + LAT + k;
            q0.push_back(e);
        end
    endtask

    task automatic drain0();
        int n = 0;
        while (q0.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("u0_drain", 128'(q0.size()), 128'd0);
    endtask

    task automatic rd0(input logic [25:0] addr, input logic [4:0] tag);
        @(negedge clk);
        a_valid = 1'b1; a_rw = 1'b0; a_addr = addr; a_tag = tag;
        wait_ready0();
        push_read0(addr, tag);
        @(negedge clk);
        a_valid = 1'b0;
        drain0();
    endtask

    logic [3:0][127:0] d;
    logic [3:0][15:0]  m;
    logic [3:0][1:0]   o;
    int acc;
    exp_t e1;

    initial begin
        a_valid = 1'b0; a_rw = 1'b0; a_addr = 26'd0; a_tag = 5'd0;
        a_dv = 1'b0; a_bits = 128'd0; a_mask = 16'd0; a_off = 2'd0;
        b_valid = 1'b0; b_rw = 1'b0; b_addr = 26'd0; b_tag = 5'd0;
        b_dv = 1'b0; b_bits = 64'd0; b_mask = 8'd0; b_off = 1'b0;

        // Reset state
        #2;
        check("rst_req_ready", 128'(a_ready), 128'd0);
        check("rst_data_ready", 128'(a_dready), 128'd0);
        check("rst_resp_valid", 128'(a_rvalid), 128'd0);
        check("rst_resp_tag", 128'(a_rtag), 128'd0);
        check("rst_resp_data", a_rdata, 128'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_ready", 128'(a_ready), 128'd1);
        check("post_rst_ready_b", 128'(b_ready), 128'd1);

        // Basic line write then read
        for (int k = 0; k < 4; k++) begin
            d[k] = 128'hA0 + 128'(k); m[k] = 16'hFFFF; o[k] = 2'(k);
        end
        wr0(26'h10, 5'd3, d, m, o);
        rd0(26'h10, 5'd7);

        // Single-byte masked write of beat 1
        for (int k = 0; k < 4; k++) begin
            d[k] = {128{1'b1}}; m[k] = 16'h0000; o[k] = 2'(k);
        end
        m[1] = 16'h0001;
        wr0(26'h10, 5'd4, d, m, o);
        rd0(26'h10, 5'd8);
        check("mask_beat1_model", model[widx(26'h10, 1)], 128'hFF);

        // Random data, reversed offsets, then random masks with duplicate offsets
        for (int k = 0; k < 4; k++) begin
            d[k] = {$urandom, $urandom, $urandom, $urandom};
            m[k] = 16'hFFFF; o[k] = 2'(3 - k);
        end
        wr0(26'h20, 5'd1, d, m, o);
        for (int k = 0; k < 4; k++) begin
            d[k] = {$urandom, $urandom, $urandom, $urandom};
            m[k] = 16'($urandom);
        end
        o[0] = 2'd1; o[1] = 2'd1; o[2] = 2'd2; o[3] = 2'd0;
        wr0(26'h20, 5'd2, d, m, o);
        rd0(26'h20, 5'd11);

        // Address wrap beyond storage depth
        rd0(26'h1010, 5'd12);

        // Back-to-back alternating requests with data_valid held high
        @(negedge clk);
        a_valid = 1'b1; a_rw = 1'b1; a_addr = 26'h30; a_tag = 5'd1;
        a_dv = 1'b1; a_bits = {4{32'hDEADBEEF}}; a_mask = 16'hFFFF; a_off = 2'd0;
        check("b2b_ready_w", 128'(a_ready), 128'd1);
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            a_rw = 1'b0; a_tag = 5'(20 + r);
            for (int k = 0; k < 4; k++) begin
                a_bits = 128'h5500 + 128'(r * 16 + k); a_off = 2'(k);
                check("b2b_wr_ready_low", 128'(a_ready), 128'd0);
                check("b2b_data_ready", 128'(a_dready), 128'd1);
                model_write(26'h30, k, a_bits, 16'hFFFF);
                @(negedge clk);
            end
            a_bits = {4{32'hDEADBEEF}};
            check("b2b_ready_r", 128'(a_ready), 128'd1);
            push_read0(26'h30, a_tag);
            @(negedge clk);
            a_rw = 1'b1;
            for (int c = 0; c < LAT - 1 + 4; c++) begin
                check("b2b_rd_ready_low", 128'(a_ready), 128'd0);
                @(negedge clk);
            end
            check("b2b_ready_after_read", 128'(a_ready), 128'd1);
        end
        // The write accepted in this cycle gets a final clean line
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            a_bits = 128'h7700 + 128'(k); a_off = 2'(k);
            model_write(26'h30, k, a_bits, 16'hFFFF);
            @(negedge clk);
        end
        a_dv = 1'b0;
        drain0();
        rd0(26'h30, 5'd25);

        // Reset during READ beat 2
        @(negedge clk);
        a_valid = 1'b1; a_rw = 1'b0; a_addr = 26'h10; a_tag = 5'd9;
        wait_ready0();
        acc = cyc;
        push_read0(26'h10, 5'd9);
        @(negedge clk);
        a_valid = 1'b0;
        while (cyc < acc + LAT + 2 && cyc < acc + 50) @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_mid_resp_valid", 128'(a_rvalid), 128'd0);
        check("rst_mid_resp_data", a_rdata, 128'd0);
        check("rst_mid_req_ready", 128'(a_ready), 128'd0);
        check("rst_mid_beats_left", 128'(q0.size()), 128'd1);
        q0.delete();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_ready_after", 128'(a_ready), 128'd1);
        repeat (8) @(negedge clk);

        // Partial write aborted by reset keeps the beats already stored
        for (int k = 0; k < 4; k++) begin
            d[k] = 128'hC0 + 128'(k); m[k] = 16'hFFFF; o[k] = 2'(k);
        end
        @(negedge clk);
        a_valid = 1'b1; a_rw = 1'b1; a_addr = 26'h20; a_tag = 5'd5;
        wait_ready0();
        @(negedge clk);
        a_valid = 1'b0;
        for (int k = 0; k < 2; k++) begin
            a_dv = 1'b1; a_bits = d[k]; a_mask = m[k]; a_off = o[k];
            model_write(26'h20, k, d[k], m[k]);
            @(negedge clk);
        end
        a_dv = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        rd0(26'h20, 5'd13);
        rd0(26'h10, 5'd14);

        // Single-beat, one-cycle-latency instance
        @(negedge clk);
        b_valid = 1'b1; b_rw = 1'b1; b_addr = 26'h10; b_tag = 5'd3;
        check("u1_ready_w", 128'(b_ready), 128'd1);
        @(negedge clk);
        b_valid = 1'b0;
        b_dv = 1'b1; b_bits = 64'hA0; b_mask = 8'hFF; b_off = 1'b0;
        check("u1_data_ready", 128'(b_dready), 128'd1);
        @(negedge clk);
        b_dv = 1'b0;
        check("u1_ready_after_wr", 128'(b_ready), 128'd1);
        b_valid = 1'b1; b_rw = 1'b0; b_tag = 5'd7;
        e1.data = 128'hA0; e1.tag = 5'd7; e1.cyc = cyc + 1;
        q1.push_back(e1);
        @(negedge clk);
        check("u1_ready_in_read", 128'(b_ready), 128'd0);
        b_tag = 5'd8;
        @(negedge clk);
        check("u1_ready_after_rd", 128'(b_ready), 128'd1);
        e1.data = 128'hA0; e1.tag = 5'd8; e1.cyc = cyc + 1;
        q1.push_back(e1);
        @(negedge clk);
        b_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("u1_drain", 128'(q1.size()), 128'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/param_backup_mem.md
PARAM_BACKUP_MEM -- requirements
Module: param_backup_mem

Interface
REQ-001 SHALL provide parameter DATA_BITS, default 128, width of one data beat.
REQ-002 SHALL provide parameter ADDR_BITS, default 26, width of the line address.
REQ-003 SHALL provide parameter TAG_BITS, default 5, width of the request/response tag.
REQ-004 SHALL provide parameter BEATS, default 4, data beats per line (power of two, >=1); OFF_BITS = max(1, log2(BEATS)).
REQ-005 SHALL provide parameter DEPTH_LOG2, default 14, log2 of storage depth in beats.
REQ-006 SHALL provide parameter LATENCY, default 4, cycles from read accept to first response beat (>=1).
REQ-007 SHALL have ports, clock and reset first (one clock; reset is asynchronous and active-high):
 clk  in  1  clock, all state on rising edge
 reset  in  1  asynchronous active-high reset
 mem_req_valid  in  1  request present
 mem_req_ready  out  1  request accepted when both high
 mem_req_rw  in  1  1=write, 0=read
 mem_req_addr  in  ADDR_BITS  line address
 mem_req_tag  in  TAG_BITS  request tag
 mem_req_data_valid  in  1  write beat present
 mem_req_data_ready  out  1  write beat accepted when both high
 mem_req_data_bits  in  DATA_BITS  write beat data
 mem_req_data_mask  in  DATA_BITS/8  byte enables, bit i covers byte i
 mem_req_data_offset  in  OFF_BITS  beat index of write beat
 mem_resp_valid  out  1  read beat valid (no backpressure)
 mem_resp_tag  out  TAG_BITS  tag of originating read
 mem_resp_data  out  DATA_BITS  read beat data

Function
REQ-008 SHALL implement FSM states IDLE, WRITE, WAIT, READ.
REQ-009 SHALL assert mem_req_ready only in IDLE; mem_req_data_ready only in WRITE.
REQ-010 SHALL on request handshake latch addr and tag; rw=1 -> WRITE, rw=0 -> WAIT with latency counter loaded to LATENCY-1.
REQ-011 SHALL in WRITE, per data handshake, update storage word index {addr,offset} truncated to DEPTH_LOG2 bits, writing only bytes with mask bit set.
REQ-012 SHALL count write beats regardless of offset value; after BEATS beats -> IDLE next cycle; duplicate offsets overwrite, no error.
REQ-013 SHALL ignore mem_req_data_valid outside WRITE; no response is generated for writes.
REQ-014 SHALL in WAIT decrement the counter each cycle; at zero -> READ (first response beat exactly LATENCY cycles after accept cycle).
REQ-015 SHALL in READ assert mem_resp_valid for BEATS consecutive cycles, beat k carrying word {addr,k}, mem_resp_tag = latched tag, then -> IDLE.
REQ-016 SHALL return read data reflecting all writes completed before the read accept.
REQ-017 SHALL wrap addresses beyond depth modulo 2^DEPTH_LOG2 (upper address bits discarded).
REQ-018 SHALL drive mem_resp_data to zero whenever mem_resp_valid is low.
REQ-019 SHALL allow back-to-back requests: new request acceptable in the cycle after the last write beat or last read beat.

Reset
REQ-020 SHALL on reset assertion immediately force IDLE, counters zero, mem_req_ready=0 while reset high, mem_req_data_ready=0, mem_resp_valid=0, mem_resp_tag=0, mem_resp_data=0.
REQ-021 SHALL abort any in-flight transaction on reset; partial writes already stored remain; storage contents not cleared.
REQ-022 SHALL assert mem_req_ready in the first cycle after reset deassertion.

Verification
REQ-023 Write line addr=0x10 tag=3, beats 0..3 = 0xA0..0xA3 full mask, then read addr=0x10 tag=7 -> resp_valid 4 cycles starting LATENCY cycles after accept, data 0xA0..0xA3, tag 7.
REQ-024 Write beat 1 of addr 0x10 data all-ones mask 0x0001 -> subsequent read beat 1 = previous value with byte 0 = 0xFF, other bytes unchanged.
REQ-025 Read addr 2^(DEPTH_LOG2-2)+0x10 -> returns same data as addr 0x10 (wrap).
REQ-026 Assert reset during READ beat 2 -> resp_valid drops immediately; after deassert mem_req_ready=1, no residual beats.
REQ-027 mem_req_valid held high with alternating rw -> ready pulses only in IDLE; each read yields exactly BEATS beats; data_valid asserted in IDLE has no storage effect.
REQ-028 Re-run REQ-023 with LATENCY=1, BEATS=1, DATA_BITS=64 -> single beat one cycle after accept.
